// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio stream sequencer.
package audio_pkg;

  localparam int CODEC_DW = 24;
  localparam int ROM_DW   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_FETCH,
    S_WRITE,
    S_MIC_WAIT,
    S_MIC_WRITE
  } state_t;

  // ROM samples are signed 16-bit. Placing them in the top bits of the codec
  // word keeps the sign bit where the codec expects it and pads with zeros.
  function automatic logic [CODEC_DW-1:0] rom_to_codec(input logic [ROM_DW-1:0] s);
    return {s, {(CODEC_DW-ROM_DW){1'b0}}};
  endfunction

endpackage

// File: rtl/audio_stream_sequencer_if.sv
// Codec read/write handshake bundle (ADC pop side and DAC push side).
interface audio_stream_sequencer_if;
  import audio_pkg::*;

  logic                read_ready;
  logic [CODEC_DW-1:0] readdata_left;
  logic [CODEC_DW-1:0] readdata_right;
  logic                read;
  logic                write_ready;
  logic                write;
  logic [CODEC_DW-1:0] writedata_left;
  logic [CODEC_DW-1:0] writedata_right;

  // Sequencer side
  modport master (
    input  read_ready, readdata_left, readdata_right, write_ready,
    output read, write, writedata_left, writedata_right
  );

  // Codec side
  modport slave (
    output read_ready, readdata_left, readdata_right, write_ready,
    input  read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_stream_sequencer_sample_tick_gen.sv
// Free-running divider producing a one-cycle sample tick every SAMPLE_DIV clocks.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1250
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [DW-1:0] div_q, div_d;

  // Tick on the last count, then wrap to zero.
  always_comb begin
    tick  = (div_q == DW'(SAMPLE_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end
endmodule

// File: rtl/audio_stream_sequencer.sv
// Paces ROM file playback into the codec DAC at the sample rate, or loops
// codec ADC samples straight back to the DAC in mic mode.
module audio_stream_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 1250,
  parameter int ROM_SIZE   = 52612,
  parameter int ADDR_W     = 16,
  parameter int ROM_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_start,
  input  logic                   play_stop,
  input  logic                   loop_en,
  input  logic                   src_sel,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [ROM_DW-1:0]      rom_q,
  audio_stream_sequencer_if.master codec,
  output logic                   playing,
  output logic                   done,
  output logic [7:0]             drop_cnt
);
  localparam int                LAT_W     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_SIZE - 1);

  logic tick;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                playing_q, playing_d;
  logic                done_q, done_d;
  logic                stop_q, stop_d;
  logic                pend_q, pend_d;
  logic [7:0]          drop_q, drop_d;
  logic [CODEC_DW-1:0] wl_q, wl_d;
  logic [CODEC_DW-1:0] wr_q, wr_d;
  logic                read_c, write_c;

  // Next-state, datapath and handshake strobes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    playing_d = playing_q;
    done_d    = 1'b0;
    stop_d    = stop_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    wl_d      = wl_q;
    wr_d      = wr_q;
    read_c    = 1'b0;
    write_c   = 1'b0;

    // A tick landing while a sample is still in flight is remembered once;
    // a second one before it is consumed is a lost sample period.
    if ((state_q == S_FETCH || state_q == S_WRITE) && tick) begin
      if (pend_q) drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      else        pend_d = 1'b1;
    end

    // Stop is deferred until the in-flight sample has been written.
    if ((state_q == S_FETCH || state_q == S_WRITE) && play_stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        playing_d = 1'b0;
        stop_d    = 1'b0;
        pend_d    = 1'b0;
        if (!src_sel) begin
          state_d = S_MIC_WAIT;
        end else if (play_start && !play_stop) begin
          addr_d    = '0;
          playing_d = 1'b1;
          state_d   = S_WAIT_TICK;
        end
      end

      S_WAIT_TICK: begin
        if (play_stop || stop_q || !src_sel) begin
          state_d   = S_IDLE;
          playing_d = 1'b0;
          stop_d    = 1'b0;
          pend_d    = 1'b0;
        end else if (tick || pend_q) begin
          pend_d  = 1'b0;
          lat_d   = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (lat_q == LAT_W'(ROM_LAT - 1)) begin
          wl_d    = rom_to_codec(rom_q);
          wr_d    = rom_to_codec(rom_q);
          state_d = S_WRITE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_WRITE: begin
        if (codec.write_ready) begin
          write_c = 1'b1;
          if (stop_q || play_stop) begin
            state_d   = S_IDLE;
            playing_d = 1'b0;
            stop_d    = 1'b0;
            pend_d    = 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            if (loop_en) begin
              addr_d  = '0;
              state_d = S_WAIT_TICK;
            end else begin
              done_d    = 1'b1;
              state_d   = S_IDLE;
              playing_d = 1'b0;
              pend_d    = 1'b0;
            end
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_WAIT_TICK;
          end
        end
      end

      S_MIC_WAIT: begin
        if (src_sel) begin
          state_d = S_IDLE;
        end else if (codec.read_ready && codec.write_ready) begin
          read_c  = 1'b1;
          wl_d    = codec.readdata_left;
          wr_d    = codec.readdata_right;
          state_d = S_MIC_WRITE;
        end
      end

      S_MIC_WRITE: begin
        if (codec.write_ready) begin
          write_c = 1'b1;
          state_d = S_MIC_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b0;
      pend_q    <= 1'b0;
      drop_q    <= '0;
      wl_q      <= '0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      stop_q    <= stop_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      wl_q      <= wl_d;
      wr_q      <= wr_d;
    end
  end

  assign rom_addr              = addr_q;
  assign playing               = playing_q;
  assign done                  = done_q;
  assign drop_cnt              = drop_q;
  assign codec.read            = read_c;
  assign codec.write           = write_c;
  assign codec.writedata_left  = wl_q;
  assign codec.writedata_right = wr_q;
endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer with a short divider and 4-word ROM.
module tb_audio_stream_sequencer;
  localparam int D  = 16;
  localparam int RS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play_start = 1'b0, play_stop = 1'b0, loop_en = 1'b0, src_sel = 1'b1;
  logic [15:0] rom_addr;
  logic [15:0] rom_q;
  logic        playing, done;
  logic [7:0]  drop_cnt;

  audio_stream_sequencer_if cif ();

  audio_stream_sequencer #(
    .SAMPLE_DIV (D),
    .ROM_SIZE   (RS),
    .ADDR_W     (16),
    .ROM_LAT    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop_en    (loop_en),
    .src_sel    (src_sel),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .codec      (cif),
    .playing    (playing),
    .done       (done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Two-cycle-latency ROM: rom[i] = 16'h8001 + i
  logic [15:0] rom_mem [0:3];
  logic [15:0] rom_s1 = '0, rom_s2 = '0;
  always @(posedge clk) begin
    rom_s1 <= rom_mem[rom_addr[1:0]];
    rom_s2 <= rom_s1;
  end
  assign rom_q = rom_s2;

  int n_tests = 0, n_fail = 0;
  int wcnt = 0, rcnt = 0, dcnt = 0, viol = 0;
  logic [23:0] wl_log [0:255];
  logic [23:0] wr_log [0:255];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Codec-side observer
  always @(negedge clk) begin
    if (!reset) begin
      if (cif.write) begin
        wl_log[wcnt[7:0]] = cif.writedata_left;
        wr_log[wcnt[7:0]] = cif.writedata_right;
        wcnt++;
        if (!cif.write_ready) viol++;
      end
      if (cif.read) rcnt++;
      if (cif.read && cif.write) viol++;
      if (done) dcnt++;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    play_start = 1'b0;
    play_stop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic stop);
    play_start = 1'b1;
    play_stop  = stop;
    @(posedge clk);
    #1;
    play_start = 1'b0;
    play_stop  = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int k = 0; k < budget && wcnt < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_reads(input int n, input int budget);
    for (int k = 0; k < budget && rcnt < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [23:0] rom_exp(input int i);
    logic [15:0] s;
    s = 16'h8001 + 16'(i);
    return {s, 8'h00};
  endfunction

  int base, dbase, rbase;

  initial begin
    for (int i = 0; i < 4; i++) rom_mem[i] = 16'h8001 + 16'(i);
    cif.read_ready = 1'b0;
    cif.write_ready = 1'b1;
    cif.readdata_left = '0;
    cif.readdata_right = '0;

    // Reset state
    #1;
    chk("rst_write", 32'(cif.write), 0);
    chk("rst_read", 32'(cif.read), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_wdata", 32'(cif.writedata_left), 0);

    // 1: reset while stalled in WRITE at address 2
    do_reset();
    base = wcnt;
    pulse_start(1'b0);
    wait_writes(base + 2, 4 * D);
    @(posedge clk);
    #1 cif.write_ready = 1'b0;
    repeat (D + 6) @(posedge clk);
    #1;
    chk("t1_addr_pre", 32'(rom_addr), 2);
    chk("t1_play_pre", 32'(playing), 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_write", 32'(cif.write), 0);
    chk("t1_playing", 32'(playing), 0);
    chk("t1_addr", 32'(rom_addr), 0);
    chk("t1_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    cif.write_ready = 1'b1;

    // 2: one-shot playback of the whole file
    do_reset();
    base = wcnt; dbase = dcnt;
    pulse_start(1'b0);
    repeat (5 * D + 10) @(posedge clk);
    #1;
    chk("t2_nwrites", 32'(wcnt - base), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_wl%0d", i), 32'(wl_log[base + i]), 32'(rom_exp(i)));
    chk("t2_wr3", 32'(wr_log[base + 3]), 32'(rom_exp(3)));
    chk("t2_done", 32'(dcnt - dbase), 1);
    chk("t2_playing", 32'(playing), 0);
    chk("t2_addr", 32'(rom_addr), 3);

    // 3: looping playback wraps to address 0
    do_reset();
    loop_en = 1'b1;
    base = wcnt; dbase = dcnt;
    pulse_start(1'b0);
    wait_writes(base + 4, 6 * D);
    @(posedge clk);
    #1;
    chk("t3_wrap_addr", 32'(rom_addr), 0);
    wait_writes(base + 5, 2 * D);
    chk("t3_nwrites", 32'(wcnt - base), 5);
    chk("t3_wl4", 32'(wl_log[base + 4]), 32'h800100);
    chk("t3_done", 32'(dcnt - dbase), 0);
    chk("t3_playing", 32'(playing), 1);
    play_stop = 1'b1;
    @(posedge clk);
    #1 play_stop = 1'b0;
    repeat (2 * D) @(posedge clk);
    #1;
    chk("t3_stopped", 32'(playing), 0);
    loop_en = 1'b0;

    // 4: codec back-pressure across three ticks drops two samples
    do_reset();
    cif.write_ready = 1'b0;
    base = wcnt;
    pulse_start(1'b0);
    repeat (68) @(posedge clk);
    #1;
    chk("t4_drop", 32'(drop_cnt), 2);
    chk("t4_nowrite", 32'(wcnt - base), 0);
    chk("t4_play_stall", 32'(playing), 1);
    cif.write_ready = 1'b1;
    wait_writes(base + 1, 10);
    chk("t4_first", 32'(wl_log[base]), 32'h800100);
    chk("t4_resume", 32'(playing), 1);
    repeat (4 * D) @(posedge clk);
    #1;
    chk("t4_nwrites", 32'(wcnt - base), 4);
    chk("t4_drop_hold", 32'(drop_cnt), 2);

    // 5: stop during FETCH finishes the current sample
    do_reset();
    base = wcnt;
    pulse_start(1'b0);
    wait_writes(base + 1, 3 * D);
    repeat (D - 2) @(posedge clk);
    #1 play_stop = 1'b1;
    @(posedge clk);
    #1 play_stop = 1'b0;
    repeat (2 * D) @(posedge clk);
    #1;
    chk("t5_nwrites", 32'(wcnt - base), 2);
    chk("t5_wl1", 32'(wl_log[base + 1]), 32'h800200);
    chk("t5_playing", 32'(playing), 0);
    base = wcnt;
    pulse_start(1'b1);
    repeat (2 * D) @(posedge clk);
    #1;
    chk("t5_startstop_play", 32'(playing), 0);
    chk("t5_startstop_wr", 32'(wcnt - base), 0);

    // 6: mic loopback
    src_sel = 1'b0;
    do_reset();
    rbase = rcnt;
    cif.readdata_left = 24'h123456;
    cif.readdata_right = 24'h654321;
    cif.read_ready = 1'b1;
    wait_reads(rbase + 1, 20);
    @(posedge clk);
    #1 cif.read_ready = 1'b0;
    chk("t6_write", 32'(cif.write), 1);
    chk("t6_read_low", 32'(cif.read), 0);
    chk("t6_wl", 32'(cif.writedata_left), 32'h123456);
    chk("t6_wr", 32'(cif.writedata_right), 32'h654321);
    @(posedge clk);
    #1;
    cif.readdata_left = 24'hABCDEF;
    cif.read_ready = 1'b1;
    wait_reads(rbase + 2, 20);
    @(posedge clk);
    #1 cif.read_ready = 1'b0;
    src_sel = 1'b1;
    chk("t6_pair_write", 32'(cif.write), 1);
    chk("t6_pair_wl", 32'(cif.writedata_left), 32'hABCDEF);
    cif.read_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_nreads", 32'(rcnt - rbase), 2);
    chk("t6_playing", 32'(playing), 0);
    cif.read_ready = 1'b0;

    chk("handshake_viol", 32'(viol), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
